// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the rv32i pipeline.
// Latency: inst_resp in cycle N is visible on if_id_* in cycle N+1 (stall low); 1 instr/cycle with zero-wait memory.
// Backpressure: stall holds if_id_*; a word returned under stall is parked in a one-entry buffer (HOLD) and fetch pauses.
// Ports: clk/rst (sync, active-high); stall, redirect/redirect_pc from downstream;
//        inst_read/inst_addr/inst_resp/inst_rdata to the I-cache; if_id_valid/pc/instr to decode;
//        fetch_busy is high while draining a stale request or holding a parked word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_read,
    output logic [31:0] inst_addr,
    input  logic        inst_resp,
    input  logic [31:0] inst_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] buf_instr, buf_instr_nxt;

    // IF/ID update request for this cycle; redirect overrides both in the register.
    logic        if_load;
    logic        if_bubble;
    logic [31:0] if_load_pc;
    logic [31:0] if_load_instr;

    logic [31:0] redirect_tgt;
    logic        redirect_pc_unused;

    // Targets are always word aligned; the low bits are ignored.
    assign redirect_tgt       = {redirect_pc[31:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign fetch_busy = (state != S_FETCH);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        buf_pc_nxt     = buf_pc;
        buf_instr_nxt  = buf_instr;
        if_load        = 1'b0;
        if_bubble      = 1'b0;
        if_load_pc     = buf_pc;
        if_load_instr  = buf_instr;
        inst_read      = 1'b0;
        inst_addr      = pc;

        case (state)
            S_FETCH: begin
                inst_read = 1'b1;
                if (redirect) begin
                    pc_nxt = redirect_tgt;
                    // Request still outstanding: keep the old address on the bus
                    // until the memory answers, then throw the answer away.
                    if (!inst_resp) begin
                        drain_addr_nxt = pc;
                        state_nxt      = S_DRAIN;
                    end
                end else if (inst_resp) begin
                    pc_nxt = pc + 32'd4;
                    if (stall) begin
                        buf_pc_nxt    = pc;
                        buf_instr_nxt = inst_rdata;
                        state_nxt     = S_HOLD;
                    end else begin
                        if_load       = 1'b1;
                        if_load_pc    = pc;
                        if_load_instr = inst_rdata;
                    end
                end else if (!stall) begin
                    if_bubble = 1'b1;
                end
            end
            S_DRAIN: begin
                inst_read = 1'b1;
                inst_addr = drain_addr;
                if (redirect) pc_nxt = redirect_tgt;
                if (inst_resp) state_nxt = S_FETCH;
                if (!stall) if_bubble = 1'b1;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = S_FETCH;
                end else if (!stall) begin
                    if_load   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase

        // A request in flight during reset is abandoned immediately.
        if (rst) inst_read = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= {RESET_PC[31:2], 2'b00};
            drain_addr  <= 32'd0;
            buf_pc      <= 32'd0;
            buf_instr   <= 32'd0;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            buf_pc     <= buf_pc_nxt;
            buf_instr  <= buf_instr_nxt;
            // if_load/if_bubble are only raised with stall low, so a stall
            // leaves the register untouched unless a redirect flushes it.
            if (redirect) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end else if (if_load) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= if_load_pc;
                if_id_instr <= if_load_instr;
            end else if (if_bubble) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run against
// an instruction-stream reference model and a variable-latency memory model.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        fetch_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_read   (inst_read),
        .inst_addr   (inst_addr),
        .inst_resp   (inst_resp),
        .inst_rdata  (inst_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .fetch_busy  (fetch_busy)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic idle_inputs();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        inst_resp = 1'b0; inst_rdata = 32'd0;
    endtask

    // Leaves the caller at a falling edge with rst just released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (inst_read !== 1'b0) begin n_err++; $display("FAIL reset_read got=%0h exp=0", inst_read); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", if_id_valid); end
        n_cmp++; if (if_id_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got=%08h exp=0", if_id_pc); end
        n_cmp++; if (if_id_instr !== NOP) begin n_err++; $display("FAIL reset_instr got=%08h exp=%08h", if_id_instr, NOP); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", fetch_busy); end
        n_cmp++; if (inst_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr got=%08h exp=%08h", inst_addr, RESET_PC); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (inst_read !== 1'b1) begin n_err++; $display("FAIL reset_release_read got=%0h exp=1", inst_read); end
    endtask

    task automatic test_stream();
        logic [31:0] p;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                p = RESET_PC + 32'(4 * (i - 1));
                n_cmp++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, if_id_valid); end
                n_cmp++; if (if_id_pc !== p) begin n_err++; $display("FAIL stream_pc[%0d] got=%08h exp=%08h", i, if_id_pc, p); end
                n_cmp++; if (if_id_instr !== mw(p)) begin n_err++; $display("FAIL stream_instr[%0d] got=%08h exp=%08h", i, if_id_instr, mw(p)); end
            end
            if (i < 3) begin
                p = RESET_PC + 32'(4 * i);
                n_cmp++; if (inst_addr !== p) begin n_err++; $display("FAIL stream_addr[%0d] got=%08h exp=%08h", i, inst_addr, p); end
                inst_resp = 1'b1; inst_rdata = mw(p);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall_hold();
        do_reset();
        inst_resp = 1'b1; inst_rdata = mw(RESET_PC);
        @(negedge clk);
        inst_rdata = mw(RESET_PC + 32'd4); stall = 1'b1;
        @(negedge clk);
        inst_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (inst_read !== 1'b0) begin n_err++; $display("FAIL hold_read[%0d] got=%0h exp=0", i, inst_read); end
            n_cmp++; if (fetch_busy !== 1'b1) begin n_err++; $display("FAIL hold_busy[%0d] got=%0h exp=1", i, fetch_busy); end
            n_cmp++; if (if_id_pc !== RESET_PC || if_id_valid !== 1'b1) begin n_err++; $display("FAIL hold_ifid[%0d] got=%08h/%0h exp=%08h/1", i, if_id_pc, if_id_valid, RESET_PC); end
            if (i == 2) stall = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (if_id_pc !== RESET_PC + 32'd4) begin n_err++; $display("FAIL hold_release_pc got=%08h exp=%08h", if_id_pc, RESET_PC + 32'd4); end
        n_cmp++; if (if_id_instr !== mw(RESET_PC + 32'd4)) begin n_err++; $display("FAIL hold_release_instr got=%08h exp=%08h", if_id_instr, mw(RESET_PC + 32'd4)); end
        n_cmp++; if (inst_read !== 1'b1 || inst_addr !== RESET_PC + 32'd8) begin n_err++; $display("FAIL hold_next_fetch got=%0h/%08h exp=1/%08h", inst_read, inst_addr, RESET_PC + 32'd8); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_err++; $display("FAIL hold_exit_busy got=%0h exp=0", fetch_busy); end
        idle_inputs();
    endtask

    task automatic test_redirect_drain();
        do_reset();
        inst_resp = 1'b1; inst_rdata = mw(32'h60);
        @(negedge clk); inst_rdata = mw(32'h64);
        @(negedge clk);
        n_cmp++; if (inst_addr !== 32'h68) begin n_err++; $display("FAIL drain_pre_addr got=%08h exp=68", inst_addr); end
        inst_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (inst_read !== 1'b1 || inst_addr !== 32'h68) begin n_err++; $display("FAIL drain_addr0 got=%0h/%08h exp=1/68", inst_read, inst_addr); end
        n_cmp++; if (fetch_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy got=%0h exp=1", fetch_busy); end
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_err++; $display("FAIL drain_flush got=%0h/%08h exp=0/%08h", if_id_valid, if_id_instr, NOP); end
        @(negedge clk);
        n_cmp++; if (inst_addr !== 32'h68) begin n_err++; $display("FAIL drain_addr1 got=%08h exp=68", inst_addr); end
        inst_resp = 1'b1; inst_rdata = mw(32'h68);
        @(negedge clk);
        inst_resp = 1'b0;
        n_cmp++; if (inst_addr !== 32'h200 || fetch_busy !== 1'b0) begin n_err++; $display("FAIL drain_refetch got=%08h/%0h exp=200/0", inst_addr, fetch_busy); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL drain_stale_valid got=%0h exp=0", if_id_valid); end
        inst_resp = 1'b1; inst_rdata = mw(32'h200);
        @(negedge clk);
        inst_resp = 1'b0;
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_instr !== mw(32'h200)) begin n_err++; $display("FAIL drain_target got=%0h/%08h/%08h exp=1/200/%08h", if_id_valid, if_id_pc, if_id_instr, mw(32'h200)); end
        idle_inputs();
    endtask

    task automatic test_redirect_stall_resp();
        do_reset();
        inst_resp = 1'b1; inst_rdata = mw(32'h60);
        @(negedge clk);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; inst_rdata = mw(32'h64);
        @(negedge clk);
        idle_inputs();
        n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_err++; $display("FAIL rsr_flush got=%0h/%08h exp=0/%08h", if_id_valid, if_id_instr, NOP); end
        n_cmp++; if (inst_read !== 1'b1 || inst_addr !== 32'h200) begin n_err++; $display("FAIL rsr_next got=%0h/%08h exp=1/200", inst_read, inst_addr); end
        n_cmp++; if (fetch_busy !== 1'b0) begin n_err++; $display("FAIL rsr_busy got=%0h exp=0", fetch_busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        inst_resp = 1'b1; inst_rdata = mw(32'h60); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (inst_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got=%08h exp=fffffffc", inst_addr); end
        inst_rdata = mw(32'hFFFF_FFFC);
        @(negedge clk);
        inst_resp = 1'b0;
        n_cmp++; if (inst_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got=%08h exp=0", inst_addr); end
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ifid got=%0h/%08h exp=1/fffffffc", if_id_valid, if_id_pc); end
        idle_inputs();
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++; if (fetch_busy !== 1'b1) begin n_err++; $display("FAIL rstd_busy got=%0h exp=1", fetch_busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (inst_read !== 1'b0) begin n_err++; $display("FAIL rstd_read got=%0h exp=0", inst_read); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (fetch_busy !== 1'b0 || inst_read !== 1'b1 || inst_addr !== RESET_PC) begin n_err++; $display("FAIL rstd_fetch got=%0h/%0h/%08h exp=0/1/%08h", fetch_busy, inst_read, inst_addr, RESET_PC); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rstd_valid got=%0h exp=0", if_id_valid); end
    endtask

    // Reference: decode consumes if_id whenever it is valid and neither stall
    // nor redirect is asserted; consumed PCs must run sequentially from the last
    // redirect target (or reset PC) and carry that address's memory word.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] maddr;
        bit          mbusy;
        int          mwait;
        int          consumed;
        exp_pc = RESET_PC; maddr = 32'd0; mbusy = 1'b0; mwait = 0; consumed = 0;
        do_reset();
        #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if (if_id_valid && !stall && !redirect) begin
                n_cmp++; if (if_id_pc !== exp_pc) begin n_err++; $display("FAIL rand_pc cyc=%0d got=%08h exp=%08h", cyc, if_id_pc, exp_pc); end
                n_cmp++; if (if_id_instr !== mw(exp_pc)) begin n_err++; $display("FAIL rand_instr cyc=%0d got=%08h exp=%08h", cyc, if_id_instr, mw(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (!if_id_valid) begin
                n_cmp++; if (if_id_instr !== NOP) begin n_err++; $display("FAIL rand_nop cyc=%0d got=%08h exp=%08h", cyc, if_id_instr, NOP); end
            end
            if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            inst_resp = 1'b0;
            if (mbusy) begin
                n_cmp++; if (inst_read !== 1'b1 || inst_addr !== maddr) begin n_err++; $display("FAIL rand_req_stable cyc=%0d got=%0h/%08h exp=1/%08h", cyc, inst_read, inst_addr, maddr); end
            end else if (inst_read) begin
                mbusy = 1'b1; maddr = inst_addr; mwait = $urandom_range(0, 2);
                n_cmp++; if (inst_addr[1:0] !== 2'b00) begin n_err++; $display("FAIL rand_align cyc=%0d got=%08h", cyc, inst_addr); end
            end
            if (mbusy) begin
                if (mwait == 0) begin
                    inst_resp = 1'b1; inst_rdata = mw(maddr); mbusy = 1'b0;
                end else begin
                    mwait--;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++; if (consumed < 200) begin n_err++; $display("FAIL rand_progress got=%0d exp>=200", consumed); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall_resp();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
